// File: rtl/adc_hold_scheduler.sv
// Arms after HOLD_PRESSES hold ticks, captures the next valid ADC sample and freezes it until release or timeout.
// All outputs are registered; a capture is visible one clock after the sampling edge. There is no backpressure.
module adc_hold_scheduler #(
  parameter int DATA_W       = 12,
  parameter int CNT_W        = 2,
  parameter int HOLD_PRESSES = 4,
  parameter int MIN_HOLD_CYC = 1000,
  parameter int TIMEOUT_CYC  = 0,
  parameter int TMR_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_tick_i,
  input  logic              release_tick_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_data_i,
  output logic              hold_enable_o,
  output logic [CNT_W-1:0]  hold_count_o,
  output logic [DATA_W-1:0] held_data_o,
  output logic              held_valid_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PRESS = CNT_W'(HOLD_PRESSES - 1);
  localparam logic [TMR_W-1:0] MIN_M1     = TMR_W'(MIN_HOLD_CYC - 1);
  localparam logic             TMO_EN     = (TIMEOUT_CYC != 0);
  localparam logic [TMR_W-1:0] TMO_M1     = TMO_EN ? TMR_W'(TIMEOUT_CYC - 1) : '0;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    hold_count_q, hold_count_d;
  logic                hold_enable_q, hold_enable_d;
  logic [DATA_W-1:0]   held_data_q, held_data_d;
  logic                held_valid_q, held_valid_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      hold_count_q  <= '0;
      hold_enable_q <= 1'b0;
      held_data_q   <= '0;
      held_valid_q  <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      hold_count_q  <= hold_count_d;
      hold_enable_q <= hold_enable_d;
      held_data_q   <= held_data_d;
      held_valid_q  <= held_valid_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_count_d  = hold_count_q;
    hold_enable_d = hold_enable_q;
    held_data_d   = held_data_q;
    held_valid_d  = held_valid_q;
    timer_d       = timer_q;
    case (state_q)
      IDLE: begin
        // Release beats a simultaneous hold tick.
        if (release_tick_i) begin
          hold_count_d = '0;
        end else if (hold_tick_i) begin
          if (hold_count_q == LAST_PRESS) begin
            hold_count_d = '0;
            state_d      = ARMED;
          end else begin
            hold_count_d = hold_count_q + CNT_W'(1);
          end
        end
      end
      ARMED: begin
        hold_count_d = '0;
        if (release_tick_i) begin
          state_d = IDLE;
        end else if (sample_valid_i) begin
          held_data_d   = sample_data_i;
          held_valid_d  = 1'b1;
          hold_enable_d = 1'b1;
          timer_d       = '0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
        // Early release pulses are dropped, not remembered.
        if ((release_tick_i && (timer_q >= MIN_M1)) || (TMO_EN && (timer_q == TMO_M1))) begin
          hold_enable_d = 1'b0;
          hold_count_d  = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        hold_enable_d = 1'b0;
        hold_count_d  = '0;
        state_d       = IDLE;
      end
    endcase
  end

  assign hold_enable_o = hold_enable_q;
  assign hold_count_o  = hold_count_q;
  assign held_data_o   = held_data_q;
  assign held_valid_o  = held_valid_q;
  assign state_o       = state_q;

endmodule
